// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display blocks: active-low segment
// codes ordered {dp,g,f,e,d,c,b,a} and the number of scanned digits.
package seg_pkg;

  localparam int DIGITS = 6;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder with blank, minus
// and decimal-point overrides. Codes 10..15 decode to blank.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  input  logic       minus,
  input  logic       dp,
  output logic [7:0] seg
);

  // Minus wins over blank, blank wins over the digit; dp is applied last.
  always_comb begin
    seg = SEG_BLANK;
    unique case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    if (minus) begin
      seg = SEG_MINUS;
    end else if (blank) begin
      seg = SEG_BLANK;
    end
    if (dp) begin
      seg[7] = 1'b0;
    end
  end

endmodule

// File: rtl/seg_dynamic_scan.sv
// Six-digit dynamic-scan driver for a common-anode display: dwell counter,
// digit index, once-per-frame input snapshot, leading-zero blanking, minus
// sign placement and registered one-hot select / active-low segment outputs.
module seg_dynamic_scan
  import seg_pkg::*;
#(
  parameter int CNT_MAX = 49_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] unit,
  input  logic [3:0] ten,
  input  logic [3:0] hun,
  input  logic [3:0] tho,
  input  logic [3:0] t_tho,
  input  logic [3:0] h_hun,
  input  logic [5:0] point,
  input  logic       sign,
  input  logic       seg_en,
  output logic [5:0] sel,
  output logic [7:0] seg
);

  localparam int CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);
  localparam logic [2:0] IDX_LAST = 3'(DIGITS - 1);

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [2:0]               idx_q, idx_d;
  logic [2:0]               idx_p1_q, idx_p1_d;
  logic                     en_p1_q, en_p1_d;
  logic [DIGITS-1:0][3:0]   dig_q, dig_d;
  logic [DIGITS-1:0]        point_q, point_d;
  logic                     sign_q, sign_d;
  logic [DIGITS-1:0]        sel_q, sel_d;
  logic [7:0]               seg_q, seg_d;
  logic [DIGITS-1:0]        blank_m;
  logic [DIGITS-1:0]        minus_m;
  logic [7:0]               dec_seg;
  logic                     take_snap;

  assign take_snap = (cnt_q == '0) && (idx_q == '0);

  // Dwell counter and digit index; both parked at zero while disabled.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!seg_en) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Stage A: delay index/enable and latch inputs at the start of each frame.
  always_comb begin
    idx_p1_d = idx_q;
    en_p1_d  = seg_en;
    dig_d    = dig_q;
    point_d  = point_q;
    sign_d   = sign_q;
    if (take_snap) begin
      dig_d   = {h_hun, t_tho, tho, hun, ten, unit};
      point_d = point;
      sign_d  = sign;
    end
  end

  // Blank mask grows down from the top digit; minus sits on its lowest bit.
  always_comb begin
    logic higher_zero;
    higher_zero = 1'b1;
    blank_m     = '0;
    minus_m     = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      higher_zero = higher_zero & (dig_q[i] == 4'd0);
      blank_m[i]  = higher_zero;
    end
    for (int i = 1; i < DIGITS; i++) begin
      minus_m[i] = sign_q & blank_m[i] & ~blank_m[i-1];
    end
  end

  bcd_to_seg u_dec (
    .code  (dig_q[idx_p1_q]),
    .blank (blank_m[idx_p1_q]),
    .minus (minus_m[idx_p1_q]),
    .dp    (point_q[idx_p1_q]),
    .seg   (dec_seg)
  );

  // Stage B: select and segment outputs, forced off while disabled.
  always_comb begin
    sel_d = '0;
    seg_d = SEG_BLANK;
    if (en_p1_q) begin
      sel_d = DIGITS'(1) << idx_p1_q;
      seg_d = dec_seg;
    end
  end

  // All state registers share the asynchronous active-low reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      idx_p1_q <= '0;
      en_p1_q  <= 1'b0;
      dig_q    <= '0;
      point_q  <= '0;
      sign_q   <= 1'b0;
      sel_q    <= '0;
      seg_q    <= SEG_BLANK;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      idx_p1_q <= idx_p1_d;
      en_p1_q  <= en_p1_d;
      dig_q    <= dig_d;
      point_q  <= point_d;
      sign_q   <= sign_d;
      sel_q    <= sel_d;
      seg_q    <= seg_d;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_dynamic_scan.sv
// Testbench for seg_dynamic_scan with CNT_MAX=4: directed frames plus random
// inputs, compared against a frame-arithmetic reference model.
module tb_seg_dynamic_scan;

  localparam int CNT_MAX = 4;
  localparam int DWELL   = CNT_MAX + 1;
  localparam int FRAME   = 6 * DWELL;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic [3:0] unit = '0, ten = '0, hun = '0, tho = '0, t_tho = '0, h_hun = '0;
  logic [5:0] point = '0;
  logic       sign = 1'b0;
  logic       seg_en = 1'b0;
  logic [5:0] sel;
  logic [7:0] seg;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  seg_dynamic_scan #(.CNT_MAX(CNT_MAX)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .unit      (unit),
    .ten       (ten),
    .hun       (hun),
    .tho       (tho),
    .t_tho     (t_tho),
    .h_hun     (h_hun),
    .point     (point),
    .sign      (sign),
    .seg_en    (seg_en),
    .sel       (sel),
    .seg       (seg)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         mdl_n = -1;            // enabled edges since enable, -1 when off
  logic [3:0] snap_dig [6];
  logic [5:0] snap_pt   = '0;
  logic       snap_sign = 1'b0;
  logic [5:0] exp_sel   = '0;
  logic [7:0] exp_seg   = 8'hFF;

  function automatic logic [7:0] digit_code(input logic [3:0] v);
    case (v)
      4'd0: return 8'hC0;  4'd1: return 8'hF9;  4'd2: return 8'hA4;
      4'd3: return 8'hB0;  4'd4: return 8'h99;  4'd5: return 8'h92;
      4'd6: return 8'h82;  4'd7: return 8'hF8;  4'd8: return 8'h80;
      4'd9: return 8'h90;  default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] ref_seg(input int k);
    int hi;
    logic [7:0] c;
    hi = 0;
    for (int i = 0; i < 6; i++) if (snap_dig[i] != 4'd0) hi = i;
    if (k > hi) c = (snap_sign && k == hi + 1) ? 8'hBF : 8'hFF;
    else        c = digit_code(snap_dig[k]);
    if (snap_pt[k]) c[7] = 1'b0;
    return c;
  endfunction

  initial for (int i = 0; i < 6; i++) snap_dig[i] = '0;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mdl_n = -1;
      for (int i = 0; i < 6; i++) snap_dig[i] = '0;
      snap_pt = '0; snap_sign = 1'b0;
      exp_sel = '0; exp_seg = 8'hFF;
    end else begin
      if (mdl_n < 0) begin
        exp_sel = '0; exp_seg = 8'hFF;
      end else begin
        exp_sel = 6'(1) << ((mdl_n / DWELL) % 6);
        exp_seg = ref_seg((mdl_n / DWELL) % 6);
      end
      mdl_n = seg_en ? ((mdl_n < 0) ? 0 : mdl_n + 1) : -1;
      if (mdl_n >= 0 && (mdl_n % FRAME) == 0) begin
        snap_dig[0] = unit;  snap_dig[1] = ten;   snap_dig[2] = hun;
        snap_dig[3] = tho;   snap_dig[4] = t_tho; snap_dig[5] = h_hun;
        snap_pt = point; snap_sign = sign;
      end
    end
  end

  always @(negedge sys_clk) begin
    if (chk_on) begin
      check_eq("model_sel", {26'd0, sel}, {26'd0, exp_sel});
      check_eq("model_seg", {24'd0, seg}, {24'd0, exp_seg});
    end
  end

  // ---------------- helpers ----------------
  task automatic set_num(input logic [3:0] d5, d4, d3, d2, d1, d0);
    h_hun = d5; t_tho = d4; tho = d3; hun = d2; ten = d1; unit = d0;
  endtask

  task automatic wait_rise(input string tag, input logic [5:0] tgt, output bit ok);
    logic [5:0] prev;
    ok   = 1'b0;
    prev = sel;
    for (int c = 0; c < 4 * FRAME; c++) begin
      @(negedge sys_clk);
      if (sel == tgt && prev != tgt) begin
        ok = 1'b1;
        break;
      end
      prev = sel;
    end
    check_eq({tag, "_reached"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic check_digits(input string tag, input logic [5:0][7:0] e, input int from_k);
    bit ok;
    wait_rise(tag, 6'(1) << from_k, ok);
    if (ok) begin
      for (int k = from_k; k < 6; k++) begin
        for (int c = 0; c < DWELL; c++) begin
          if (!(k == from_k && c == 0)) @(negedge sys_clk);
          check_eq({tag, "_sel"}, {26'd0, sel}, {26'd0, 6'(1) << k});
          check_eq({tag, "_seg"}, {24'd0, seg}, {24'd0, e[k]});
        end
      end
    end
  endtask

  task automatic next_frame_check(input string tag, input logic [5:0][7:0] e);
    bit ok;
    wait_rise({tag, "_skip"}, 6'b000001, ok);
    check_digits(tag, e, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    localparam logic [5:0][7:0] F_987665 = {8'h90, 8'h80, 8'hF8, 8'h82, 8'h82, 8'h92};
    localparam logic [5:0][7:0] F_005478 = {8'hFF, 8'hFF, 8'h92, 8'h99, 8'hF8, 8'h80};

    seg_en = 1'b1;
    set_num(4'd9, 4'd8, 4'd7, 4'd6, 4'd6, 4'd5);
    #1 sys_rst_n = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(negedge sys_clk);
    check_eq("reset_sel", {26'd0, sel}, 32'd0);
    check_eq("reset_seg", {24'd0, seg}, 32'hFF);
    sys_rst_n = 1'b1;

    // 1: full-width value straight out of reset
    check_digits("t1_987665", F_987665, 0);

    // 2: leading-zero blanking
    set_num(4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 4'd8);
    next_frame_check("t2_blank", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF8, 8'h80});

    // 3: minus sign and decimal point
    set_num(4'd0, 4'd0, 4'd0, 4'd3, 4'd2, 4'd1);
    sign = 1'b1; point = 6'b000100;
    next_frame_check("t3_sign_dp", {8'hFF, 8'hFF, 8'hBF, 8'h30, 8'hA4, 8'hF9});
    sign = 1'b0; point = '0;

    // 4: input change in the middle of a frame
    set_num(4'd9, 4'd8, 4'd7, 4'd6, 4'd6, 4'd5);
    next_frame_check("t4_pre", F_987665);
    wait_rise("t4_mid", 6'b000100, ok);
    set_num(4'd0, 4'd0, 4'd5, 4'd4, 4'd7, 4'd8);
    check_digits("t4_rest", F_987665, 3);
    check_digits("t4_next", F_005478, 0);

    // 5: enable drop and re-enable
    repeat (7) @(negedge sys_clk);
    seg_en = 1'b0;
    repeat (2) @(negedge sys_clk);
    check_eq("t5_off_sel", {26'd0, sel}, 32'd0);
    check_eq("t5_off_seg", {24'd0, seg}, 32'hFF);
    repeat (4) @(negedge sys_clk);
    seg_en = 1'b1;
    @(negedge sys_clk);
    check_eq("t5_on1_sel", {26'd0, sel}, 32'd0);
    @(negedge sys_clk);
    check_eq("t5_on2_sel", {26'd0, sel}, 32'd1);
    check_eq("t5_on2_seg", {24'd0, seg}, 32'h80);
    set_num(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    next_frame_check("t5_zero", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});
    set_num(4'd0, 4'd0, 4'd0, 4'd0, 4'hA, 4'd3);
    next_frame_check("t5_code_a", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hB0});

    // 6: asynchronous reset mid-operation
    set_num(4'd9, 4'd8, 4'd7, 4'd6, 4'd6, 4'd5);
    wait_rise("t6_idx3", 6'b001000, ok);
    #2 sys_rst_n = 1'b0;
    #1;
    check_eq("t6_rst_sel", {26'd0, sel}, 32'd0);
    check_eq("t6_rst_seg", {24'd0, seg}, 32'hFF);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    check_digits("t6_restart", F_987665, 0);

    // random inputs, enable toggles, against the model
    for (int it = 0; it < 40; it++) begin
      @(negedge sys_clk);
      unit  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      ten   = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      hun   = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
      tho   = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
      t_tho = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
      h_hun = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
      point = 6'($urandom);
      sign  = 1'($urandom);
      seg_en = ($urandom_range(0, 9) != 0);
      repeat ($urandom_range(1, 40)) @(negedge sys_clk);
    end

    @(negedge sys_clk);
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
